// File: rtl/prio_encoder_pkg.sv
// Shared types, limits and width helper for the prio_encoder_rr block.
package prio_encoder_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } arb_mode_t;

    localparam int N_MIN = 2;
    localparam int N_MAX = 256;

    // Index width, never narrower than one bit.
    function automatic int idx_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_find_from_ptr.sv
// Combinational search for the first set bit of vec, scanning downward from
// start and wrapping from 0 to N-1: rotate, find-highest, un-rotate.
module prio_find_from_ptr #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    // (base + off) mod N for off in 0..N; a single subtraction covers the wrap.
    function automatic logic [W-1:0] wrap(input logic [W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return W'(s);
    endfunction

    logic [N-1:0] rot;
    logic [W-1:0] hi;

    // vec[start] lands on rot[N-1], so the downward scan becomes find-highest.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            rot[j] = vec[wrap(start, j + 1)];
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        found = 1'b0;
        hi    = '0;
        for (int j = 0; j < N; j++) begin
            if (rot[j]) begin
                found = 1'b1;
                hi    = W'(j);
            end
        end
    end

    assign idx = wrap(hi, int'(start) + 1);

endmodule

// File: rtl/prio_encoder_rr.sv
// N-input priority encoder (fixed or round-robin) with a registered grant and valid/ready handshake.
// Optional macro PRIO_ENCODER_RR_MASK_EN adds a per-source req_mask input.
module prio_encoder_rr
    import prio_encoder_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_w(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mode,
`ifdef PRIO_ENCODER_RR_MASK_EN
    input  logic [N-1:0] req_mask,
`endif
    output logic [W-1:0] grant_idx,
    output logic         grant_valid,
    input  logic         grant_ready,
    output logic         any_req
);

    if (N < N_MIN || N > N_MAX) begin : g_bad_n
        $error("prio_encoder_rr: N=%0d outside legal range %0d..%0d", N, N_MIN, N_MAX);
    end

    localparam logic [W-1:0] LAST = W'(N - 1);

    arb_mode_t    arb_mode;
    logic [N-1:0] eff_req;
    logic [W-1:0] rr_ptr;
    logic [W-1:0] ptr_next;
    logic [W-1:0] start;
    logic [W-1:0] sel_idx;
    logic         found;
    logic         handshake;
    logic         load;

    assign arb_mode = arb_mode_t'(mode);

`ifdef PRIO_ENCODER_RR_MASK_EN
    assign eff_req = req & ~req_mask;
`else
    assign eff_req = req;
`endif

    assign any_req   = |eff_req;
    assign handshake = grant_valid && grant_ready;
    assign load      = !grant_valid || grant_ready;

    // The retiring grant moves the pointer now, so a back-to-back load already searches below it.
    always_comb begin
        ptr_next = rr_ptr;
        if (handshake && arb_mode == MODE_RR) begin
            ptr_next = (grant_idx == '0) ? LAST : grant_idx - W'(1);
        end
    end

    assign start = (arb_mode == MODE_RR) ? ptr_next : LAST;

    prio_find_from_ptr #(
        .N(N),
        .W(W)
    ) u_find (
        .vec  (eff_req),
        .start(start),
        .found(found),
        .idx  (sel_idx)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            rr_ptr      <= LAST;
        end else begin
            rr_ptr <= ptr_next;
            if (load) begin
                grant_valid <= found;
                if (found) grant_idx <= sel_idx;
            end
        end
    end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Self-checking bench for prio_encoder_rr (N=8): directed table, fixed sweep,
// randomized run against a behavioural model; mask checks when PRIO_ENCODER_RR_MASK_EN is set.
module tb_prio_encoder_rr;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic         mode;
    logic [N-1:0] req_mask;
    logic [W-1:0] grant_idx;
    logic         grant_valid;
    logic         grant_ready;
    logic         any_req;

    int tests = 0;
    int fails = 0;

    // Reference state
    bit m_valid;
    int m_idx;
    int m_ptr;

    always #5 clk = ~clk;

    prio_encoder_rr #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .mode       (mode),
`ifdef PRIO_ENCODER_RR_MASK_EN
        .req_mask   (req_mask),
`endif
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .grant_ready(grant_ready),
        .any_req    (any_req)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // First set bit scanning downward from start with wrap-around; -1 if none.
    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start - k + N) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // Next reference state from the inputs present just before the clock edge.
    task automatic model_update();
        logic [N-1:0] eff;
        int           p;
`ifdef PRIO_ENCODER_RR_MASK_EN
        eff = req & ~req_mask;
`else
        eff = req;
`endif
        if (!rst_n) begin
            m_valid = 1'b0;
            m_idx   = 0;
            m_ptr   = N - 1;
        end else begin
            if (m_valid && grant_ready && mode) m_ptr = (m_idx == 0) ? N - 1 : m_idx - 1;
            if (!m_valid || grant_ready) begin
                p = pick(eff, mode ? m_ptr : N - 1);
                if (p >= 0) begin
                    m_valid = 1'b1;
                    m_idx   = p;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    endtask

    // Apply inputs, check any_req, advance model and DUT by one edge.
    task automatic step(input logic r_n, input logic [N-1:0] rq, input logic md, input logic rdy);
        logic [N-1:0] eff;
        rst_n       = r_n;
        req         = rq;
        mode        = md;
        grant_ready = rdy;
        #1;
`ifdef PRIO_ENCODER_RR_MASK_EN
        eff = rq & ~req_mask;
`else
        eff = rq;
`endif
        check("any_req", int'(any_req), int'(eff != '0));
        model_update();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         rst_n;
        logic [N-1:0] req;
        logic         mode;
        logic         ready;
        logic         exp_v;
        int           exp_i;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic [N-1:0] rq, input logic md,
                                input logic rdy, input logic v, input int i);
        vec_t e;
        e.rst_n = r; e.req = rq; e.mode = md; e.ready = rdy; e.exp_v = v; e.exp_i = i;
        tbl.push_back(e);
    endfunction

    initial begin
        logic [N-1:0] rq;
        logic         md;

        rst_n = 1'b0; req = '0; mode = 1'b0; grant_ready = 1'b0; req_mask = '0;
        m_valid = 1'b0; m_idx = 0; m_ptr = N - 1;

        // Reset, then a first fixed grant
        add(0, 8'hFF, 0, 1, 0, 0);
        add(1, 8'hFF, 0, 1, 1, 7);
        // Round-robin from a fresh pointer: 7,4,1,7,4,1
        add(0, 8'h92, 1, 1, 0, 0);
        add(1, 8'h92, 1, 1, 1, 7);
        add(1, 8'h92, 1, 1, 1, 4);
        add(1, 8'h92, 1, 1, 1, 1);
        add(1, 8'h92, 1, 1, 1, 7);
        add(1, 8'h92, 1, 1, 1, 4);
        add(1, 8'h92, 1, 1, 1, 1);
        // Backpressure: grant 5 held while req changes to 01
        add(1, 8'h20, 0, 1, 1, 5);
        for (int k = 0; k < 4; k++) add(1, 8'h01, 0, 0, 1, 5);
        add(1, 8'h01, 0, 1, 1, 0);
        // No request: valid drops, index holds
        add(1, 8'h00, 0, 1, 0, 0);
        add(1, 8'h08, 0, 1, 1, 3);
        add(1, 8'h00, 0, 1, 0, 3);
        add(1, 8'h00, 0, 1, 0, 3);
        // Reset with an outstanding RR grant and ready high: pointer returns to 7
        add(1, 8'h0F, 1, 1, 1, 3);
        add(1, 8'h0F, 1, 0, 1, 3);
        add(0, 8'h0F, 1, 1, 0, 0);
        add(1, 8'h0F, 1, 1, 1, 3);
        add(1, 8'h0F, 1, 1, 1, 2);
        // Mode toggled while held; fixed-mode handshake leaves the pointer alone
        add(1, 8'h0F, 1, 0, 1, 2);
        add(1, 8'h0F, 0, 0, 1, 2);
        add(1, 8'h0F, 0, 1, 1, 3);
        add(1, 8'h0F, 1, 1, 1, 2);
        add(1, 8'h0F, 1, 1, 1, 1);
        add(1, 8'h0F, 1, 1, 1, 0);
        add(1, 8'h0F, 1, 1, 1, 3);

        foreach (tbl[i]) begin
            step(tbl[i].rst_n, tbl[i].req, tbl[i].mode, tbl[i].ready);
            check($sformatf("tbl[%0d] valid", i), int'(grant_valid), int'(tbl[i].exp_v));
            check($sformatf("tbl[%0d] idx", i), int'(grant_idx), tbl[i].exp_i);
        end

        // Fixed-priority sweep over every request pattern
        step(0, '0, 0, 1);
        for (int r = 0; r < 256; r++) begin
            step(1, N'(r), 0, 1);
            check($sformatf("sweep %0d valid", r), int'(grant_valid), int'(m_valid));
            check($sformatf("sweep %0d idx", r), int'(grant_idx), m_idx);
        end

`ifdef PRIO_ENCODER_RR_MASK_EN
        req_mask = 8'h80;
        step(0, 8'hFF, 0, 1);
        step(1, 8'hFF, 0, 1);
        check("mask80 valid", int'(grant_valid), 1);
        check("mask80 idx", int'(grant_idx), 6);
        req_mask = 8'hFF;
        step(1, 8'hFF, 0, 1);
        check("maskFF valid", int'(grant_valid), 0);
        check("maskFF any_req", int'(any_req), 0);
        req_mask = '0;
`endif

        // Randomized run against the reference model
        md = 1'b0;
        for (int t = 0; t < 800; t++) begin
            rq = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom & $urandom);
            if ($urandom_range(0, 9) == 0) md = ~md;
`ifdef PRIO_ENCODER_RR_MASK_EN
            req_mask = N'($urandom & $urandom & $urandom);
`endif
            step(($urandom_range(0, 49) != 0), rq, md, ($urandom_range(0, 3) != 0));
            check($sformatf("rand %0d valid", t), int'(grant_valid), int'(m_valid));
            check($sformatf("rand %0d idx", t), int'(grant_idx), m_idx);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
